// File: rtl/chx_pkg.sv
// Shared types and defaults for the channel CBUS memory responder.
package chx_pkg;

  localparam int unsigned AdrWDefault  = 22;
  localparam int unsigned DataWDefault = 36;
  localparam int unsigned ChNumW       = 3;

  typedef logic [ChNumW-1:0] ch_num_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StDone,
    StErr,
    StHold
  } state_e;

endpackage

// File: rtl/chx_cbus_resp_if.sv
// Channel-request and MB-port signals seen by the CBUS responder.
interface chx_cbus_resp_if import chx_pkg::*; #(
  parameter int unsigned ADR_W  = AdrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              ch_cbus_req_h;
  logic              ch_store_h;
  ch_num_t           ch_num_h;
  logic [ADR_W-1:0]  ch_adr_h;
  logic [DATA_W-1:0] ch_data_h;
  logic              chx_data_take_h;
  logic              chx_data_valid_h;
  logic [DATA_W-1:0] chx_data_h;
  logic              chx_cbus_ack_h;
  ch_num_t           chx_ack_num_h;
  logic              chx_err_h;
  logic              chx_busy_h;
  logic              mb_req_h;
  logic              mb_wr_h;
  logic [ADR_W-1:0]  mb_adr_h;
  logic [DATA_W-1:0] mb_wdata_h;
  logic              mb_ack_h;
  logic              mb_word_en_h;
  logic [DATA_W-1:0] mb_rdata_h;

  // Requester side: channel control plus the MB memory buffer.
  modport master (
    output ch_cbus_req_h, ch_store_h, ch_num_h, ch_adr_h, ch_data_h,
    output mb_ack_h, mb_word_en_h, mb_rdata_h,
    input  chx_data_take_h, chx_data_valid_h, chx_data_h, chx_cbus_ack_h,
    input  chx_ack_num_h, chx_err_h, chx_busy_h,
    input  mb_req_h, mb_wr_h, mb_adr_h, mb_wdata_h
  );

  modport slave (
    input  ch_cbus_req_h, ch_store_h, ch_num_h, ch_adr_h, ch_data_h,
    input  mb_ack_h, mb_word_en_h, mb_rdata_h,
    output chx_data_take_h, chx_data_valid_h, chx_data_h, chx_cbus_ack_h,
    output chx_ack_num_h, chx_err_h, chx_busy_h,
    output mb_req_h, mb_wr_h, mb_adr_h, mb_wdata_h
  );

endinterface

// File: rtl/chx_timeout.sv
// Clear/count counter that flags the cycle in which it would reach TIMEOUT.
module chx_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired_o = count_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/chx_cbus_resp.sv
// Memory-side CBUS responder: one channel request at a time, quad-word burst to/from MB.
module chx_cbus_resp import chx_pkg::*; #(
  parameter int unsigned ADR_W         = AdrWDefault,
  parameter int unsigned DATA_W        = DataWDefault,
  parameter int unsigned WORDS_PER_REQ = 4,
  parameter int unsigned TIMEOUT       = 15
) (
  input logic           clk_chx_h,
  input logic           chx_reset_l,
  chx_cbus_resp_if.slave bus
);

  localparam int unsigned WcntW = $clog2(WORDS_PER_REQ) + 1;

  state_e            state_q;
  ch_num_t           num_q;
  ch_num_t           ack_num_q;
  logic [ADR_W-1:0]  adr_q;
  logic              store_q;
  logic [WcntW-1:0]  wcnt_q;
  logic              mb_req_q;
  logic              ack_q;
  logic              err_q;
  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;

  logic       to_clear;
  logic       to_count;
  logic       to_expired;
  logic       xfer;
  logic       active;
  logic       word_last;
  logic [1:0] word_off;

  // The same counter times the ack wait and each inter-word gap.
  always_comb begin
    to_clear = 1'b1;
    to_count = 1'b0;
    case (state_q)
      StReq: begin
        if (!bus.mb_ack_h) begin
          to_clear = 1'b0;
          to_count = 1'b1;
        end
      end
      StXfer: begin
        if (!bus.mb_word_en_h) begin
          to_clear = 1'b0;
          to_count = 1'b1;
        end
      end
      default: ;
    endcase
  end

  chx_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_chx_h),
    .rst_ni    (chx_reset_l),
    .clear_i   (to_clear),
    .count_i   (to_count),
    .expired_o (to_expired)
  );

  assign word_last = (wcnt_q == WcntW'(WORDS_PER_REQ - 1));
  assign word_off  = 2'(wcnt_q);

  always_ff @(posedge clk_chx_h or negedge chx_reset_l) begin
    if (!chx_reset_l) begin
      state_q   <= StIdle;
      num_q     <= '0;
      ack_num_q <= '0;
      adr_q     <= '0;
      store_q   <= 1'b0;
      wcnt_q    <= '0;
      mb_req_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ack_num_q <= '0;
      valid_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.ch_cbus_req_h) begin
            num_q    <= bus.ch_num_h;
            adr_q    <= bus.ch_adr_h;
            store_q  <= bus.ch_store_h;
            wcnt_q   <= '0;
            mb_req_q <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          // A grant arriving in the expiry cycle still wins.
          if (bus.mb_ack_h) begin
            mb_req_q <= 1'b0;
            wcnt_q   <= '0;
            state_q  <= StXfer;
          end else if (to_expired) begin
            mb_req_q  <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
            ack_num_q <= num_q;
            state_q   <= StErr;
          end
        end
        StXfer: begin
          if (bus.mb_word_en_h) begin
            wcnt_q <= wcnt_q + WcntW'(1);
            if (!store_q) begin
              rdata_q <= bus.mb_rdata_h;
              valid_q <= 1'b1;
            end
            if (word_last) begin
              ack_q     <= 1'b1;
              ack_num_q <= num_q;
              state_q   <= StDone;
            end
          end else if (to_expired) begin
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
            ack_num_q <= num_q;
            state_q   <= StErr;
          end
        end
        StDone, StErr: state_q <= StHold;
        // Request is ignored here so a still-dropping request does not restart.
        StHold: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign xfer   = (state_q == StXfer);
  assign active = (state_q == StReq) || xfer;

  assign bus.mb_req_h         = mb_req_q;
  assign bus.mb_wr_h          = active && store_q;
  assign bus.mb_adr_h         = active ? {adr_q[ADR_W-1:2], adr_q[1:0] + word_off} : '0;
  assign bus.mb_wdata_h       = (xfer && store_q) ? bus.ch_data_h : '0;
  assign bus.chx_data_take_h  = xfer && store_q && bus.mb_word_en_h;
  assign bus.chx_data_valid_h = valid_q;
  assign bus.chx_data_h       = rdata_q;
  assign bus.chx_cbus_ack_h   = ack_q;
  assign bus.chx_err_h        = err_q;
  assign bus.chx_ack_num_h    = ack_num_q;
  assign bus.chx_busy_h       = (state_q != StIdle);

endmodule

// File: tb/tb_chx_cbus_resp.sv
// Directed bench for chx_cbus_resp: read, wrapped store, timeouts, hold and reset cases.
module tb_chx_cbus_resp;

  localparam int unsigned ADR_W  = 22;
  localparam int unsigned DATA_W = 36;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  chx_cbus_resp_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  chx_cbus_resp #(
    .ADR_W         (ADR_W),
    .DATA_W        (DATA_W),
    .WORDS_PER_REQ (4),
    .TIMEOUT       (15)
  ) dut (
    .clk_chx_h   (clk),
    .chx_reset_l (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.ch_cbus_req_h = 1'b0;
    bus.ch_store_h    = 1'b0;
    bus.ch_num_h      = '0;
    bus.ch_adr_h      = '0;
    bus.ch_data_h     = '0;
    bus.mb_ack_h      = 1'b0;
    bus.mb_word_en_h  = 1'b0;
    bus.mb_rdata_h    = '0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    ctl = {bus.chx_busy_h, bus.mb_req_h, bus.mb_wr_h, bus.chx_cbus_ack_h, bus.chx_err_h,
           bus.chx_data_valid_h, bus.chx_data_take_h};
    n_vec++; if (ctl !== 7'b0) begin n_err++; $display("FAIL rst_ctl: got %b want 0", ctl); end
    n_vec++; if (bus.mb_adr_h !== '0) begin
      n_err++; $display("FAIL rst_adr: got %o want 0", bus.mb_adr_h); end
    n_vec++; if (bus.chx_data_h !== '0) begin
      n_err++; $display("FAIL rst_data: got %h want 0", bus.chx_data_h); end
    n_vec++; if (bus.chx_ack_num_h !== 3'd0) begin
      n_err++; $display("FAIL rst_num: got %0d want 0", bus.chx_ack_num_h); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL rst_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  task automatic test_read_quad();
    logic [ADR_W-1:0] ea;
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b0; bus.ch_num_h = 3'd5;
    bus.ch_adr_h = 22'o1234;
    #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL rd_idle_busy: got %b want 0", bus.chx_busy_h); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mb_ack_h = (i == 2); #1;
      n_vec++; if (bus.mb_req_h !== 1'b1 || bus.mb_wr_h !== 1'b0) begin
        n_err++; $display("FAIL rd_req c%0d: got req %b wr %b want 1 0", i, bus.mb_req_h,
                          bus.mb_wr_h); end
      n_vec++; if (bus.mb_adr_h !== 22'o1234) begin
        n_err++; $display("FAIL rd_req_adr: got %o want 1234", bus.mb_adr_h); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mb_ack_h = 1'b0; bus.mb_word_en_h = 1'b1; bus.mb_rdata_h = DATA_W'(i + 1);
      #1;
      ea = ADR_W'(22'o1234 + i);
      n_vec++; if (bus.mb_adr_h !== ea || bus.mb_req_h !== 1'b0) begin
        n_err++; $display("FAIL rd_adr w%0d: got %o req %b want %o req 0", i, bus.mb_adr_h,
                          bus.mb_req_h, ea); end
      n_vec++; if (bus.chx_data_valid_h !== (i != 0) || bus.chx_cbus_ack_h !== 1'b0) begin
        n_err++; $display("FAIL rd_valid w%0d: got valid %b ack %b want %b 0", i,
                          bus.chx_data_valid_h, bus.chx_cbus_ack_h, (i != 0)); end
      if (i != 0) begin
        n_vec++; if (bus.chx_data_h !== DATA_W'(i)) begin
          n_err++; $display("FAIL rd_data w%0d: got %h want %h", i, bus.chx_data_h, i); end
      end
    end
    @(negedge clk); bus.mb_word_en_h = 1'b0; bus.ch_cbus_req_h = 1'b0; #1;
    n_vec++; if (bus.chx_data_valid_h !== 1'b1 || bus.chx_data_h !== 36'd4) begin
      n_err++; $display("FAIL rd_last: got valid %b data %h want 1 4", bus.chx_data_valid_h,
                        bus.chx_data_h); end
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b1 || bus.chx_err_h !== 1'b0 ||
                 bus.chx_ack_num_h !== 3'd5) begin
      n_err++; $display("FAIL rd_ack: got ack %b err %b num %0d want 1 0 5", bus.chx_cbus_ack_h,
                        bus.chx_err_h, bus.chx_ack_num_h); end
    @(negedge clk); #1;
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b0 || bus.chx_data_valid_h !== 1'b0 ||
                 bus.chx_busy_h !== 1'b1) begin
      n_err++; $display("FAIL rd_hold: got ack %b valid %b busy %b want 0 0 1",
                        bus.chx_cbus_ack_h, bus.chx_data_valid_h, bus.chx_busy_h); end
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL rd_end_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  task automatic test_store_wrap();
    logic [DATA_W-1:0] wd [4];
    logic [ADR_W-1:0]  at [4];
    int w;
    int takes;
    wd = '{36'h0AAAAAAAA, 36'h0BBBBBBBB, 36'h0CCCCCCCC, 36'h0DDDDDDDD};
    at = '{22'o1236, 22'o1237, 22'o1234, 22'o1235};
    w = 0;
    takes = 0;
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b1; bus.ch_num_h = 3'd2;
    bus.ch_adr_h = 22'o1236; bus.ch_data_h = wd[0];
    @(negedge clk); bus.mb_ack_h = 1'b1; #1;
    n_vec++; if (bus.mb_req_h !== 1'b1 || bus.mb_wr_h !== 1'b1 || bus.mb_adr_h !== 22'o1236) begin
      n_err++; $display("FAIL st_req: got req %b wr %b adr %o want 1 1 1236", bus.mb_req_h,
                        bus.mb_wr_h, bus.mb_adr_h); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.mb_ack_h = 1'b0; bus.mb_word_en_h = (c != 2); bus.ch_data_h = wd[w];
      #1;
      if (bus.chx_data_take_h === 1'b1) takes++;
      n_vec++; if (bus.chx_data_take_h !== (c != 2) || bus.mb_adr_h !== at[w]) begin
        n_err++; $display("FAIL st_word c%0d: got take %b adr %o want %b %o", c,
                          bus.chx_data_take_h, bus.mb_adr_h, (c != 2), at[w]); end
      n_vec++; if (bus.mb_wdata_h !== wd[w] || bus.mb_wr_h !== 1'b1) begin
        n_err++; $display("FAIL st_wdata c%0d: got %h wr %b want %h 1", c, bus.mb_wdata_h,
                          bus.mb_wr_h, wd[w]); end
      if (c != 2) w++;
    end
    @(negedge clk); bus.mb_word_en_h = 1'b0; bus.ch_cbus_req_h = 1'b0; #1;
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b1 || bus.chx_err_h !== 1'b0 ||
                 bus.chx_ack_num_h !== 3'd2) begin
      n_err++; $display("FAIL st_ack: got ack %b err %b num %0d want 1 0 2", bus.chx_cbus_ack_h,
                        bus.chx_err_h, bus.chx_ack_num_h); end
    n_vec++; if (takes !== 4) begin
      n_err++; $display("FAIL st_takes: got %0d want 4", takes); end
    bus.ch_store_h = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL st_end_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  task automatic test_nxm();
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b0; bus.ch_num_h = 3'd3;
    bus.ch_adr_h = 22'o777;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      n_vec++; if (bus.mb_req_h !== 1'b1 || bus.chx_cbus_ack_h !== 1'b0) begin
        n_err++; $display("FAIL nxm_wait c%0d: got req %b ack %b want 1 0", c, bus.mb_req_h,
                          bus.chx_cbus_ack_h); end
    end
    @(negedge clk); bus.ch_cbus_req_h = 1'b0; #1;
    n_vec++; if (bus.mb_req_h !== 1'b0 || bus.chx_cbus_ack_h !== 1'b1 ||
                 bus.chx_err_h !== 1'b1 || bus.chx_ack_num_h !== 3'd3) begin
      n_err++; $display("FAIL nxm_err: got req %b ack %b err %b num %0d want 0 1 1 3",
                        bus.mb_req_h, bus.chx_cbus_ack_h, bus.chx_err_h, bus.chx_ack_num_h); end
    @(negedge clk); #1;
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b0 || bus.chx_err_h !== 1'b0 ||
                 bus.chx_busy_h !== 1'b1) begin
      n_err++; $display("FAIL nxm_hold: got ack %b err %b busy %b want 0 0 1",
                        bus.chx_cbus_ack_h, bus.chx_err_h, bus.chx_busy_h); end
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL nxm_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  task automatic test_word_gap();
    int valids;
    valids = 0;
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b0; bus.ch_num_h = 3'd6;
    bus.ch_adr_h = 22'o2000;
    @(negedge clk); bus.mb_ack_h = 1'b1;
    @(negedge clk); bus.mb_ack_h = 1'b0; bus.mb_word_en_h = 1'b1; bus.mb_rdata_h = 36'h11;
    @(negedge clk); bus.mb_rdata_h = 36'h22; #1;
    if (bus.chx_data_valid_h === 1'b1) valids++;
    n_vec++; if (bus.chx_data_h !== 36'h11) begin
      n_err++; $display("FAIL gap_data1: got %h want 11", bus.chx_data_h); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); bus.mb_word_en_h = 1'b0; #1;
      if (bus.chx_data_valid_h === 1'b1) valids++;
      n_vec++; if (bus.chx_cbus_ack_h !== 1'b0 || bus.mb_req_h !== 1'b0) begin
        n_err++; $display("FAIL gap_wait c%0d: got ack %b req %b want 0 0", c,
                          bus.chx_cbus_ack_h, bus.mb_req_h); end
    end
    @(negedge clk); bus.ch_cbus_req_h = 1'b0; #1;
    if (bus.chx_data_valid_h === 1'b1) valids++;
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b1 || bus.chx_err_h !== 1'b1 ||
                 bus.chx_ack_num_h !== 3'd6) begin
      n_err++; $display("FAIL gap_err: got ack %b err %b num %0d want 1 1 6",
                        bus.chx_cbus_ack_h, bus.chx_err_h, bus.chx_ack_num_h); end
    n_vec++; if (valids !== 2 || bus.chx_data_h !== 36'h22) begin
      n_err++; $display("FAIL gap_valids: got %0d data %h want 2 22", valids, bus.chx_data_h); end
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL gap_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  task automatic test_back_to_back();
    int reqs;
    reqs = 0;
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b0; bus.ch_num_h = 3'd1;
    bus.ch_adr_h = 22'o40;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk); bus.mb_ack_h = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); bus.mb_ack_h = 1'b0; bus.mb_word_en_h = 1'b1;
        bus.mb_rdata_h = DATA_W'(16 * op + i);
      end
      @(negedge clk); bus.mb_word_en_h = 1'b0; #1;
      n_vec++; if (bus.chx_cbus_ack_h !== 1'b1 || bus.chx_ack_num_h !== 3'd1) begin
        n_err++; $display("FAIL b2b_ack op%0d: got ack %b num %0d want 1 1", op,
                          bus.chx_cbus_ack_h, bus.chx_ack_num_h); end
      if (op == 0) begin
        // Request left high: HOLD ignores it, IDLE takes it as a new one.
        @(negedge clk); #1;
        n_vec++; if (bus.mb_req_h !== 1'b0 || bus.chx_busy_h !== 1'b1) begin
          n_err++; $display("FAIL b2b_hold: got req %b busy %b want 0 1", bus.mb_req_h,
                            bus.chx_busy_h); end
        @(negedge clk); #1;
        n_vec++; if (bus.mb_req_h !== 1'b0 || bus.chx_busy_h !== 1'b0) begin
          n_err++; $display("FAIL b2b_idle: got req %b busy %b want 0 0", bus.mb_req_h,
                            bus.chx_busy_h); end
        @(negedge clk); bus.ch_cbus_req_h = 1'b0; #1;
        n_vec++; if (bus.mb_req_h !== 1'b1) begin
          n_err++; $display("FAIL b2b_req: got %b want 1", bus.mb_req_h); end
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (bus.mb_req_h !== 1'b0) reqs++;
    end
    n_vec++; if (reqs !== 0 || bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL b2b_dup: got %0d extra req busy %b want 0 0", reqs,
                        bus.chx_busy_h); end
  endtask

  task automatic test_reset_mid_xfer();
    int acks;
    logic [6:0] ctl;
    acks = 0;
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b0; bus.ch_num_h = 3'd4;
    bus.ch_adr_h = 22'o100;
    @(negedge clk); bus.mb_ack_h = 1'b1;
    @(negedge clk); bus.mb_ack_h = 1'b0; bus.mb_word_en_h = 1'b1; bus.mb_rdata_h = 36'h5A;
    @(negedge clk); bus.mb_rdata_h = 36'h5B;
    @(negedge clk); bus.mb_word_en_h = 1'b0; bus.ch_cbus_req_h = 1'b0; rst_n = 1'b0; #1;
    ctl = {bus.chx_busy_h, bus.mb_req_h, bus.mb_wr_h, bus.chx_cbus_ack_h, bus.chx_err_h,
           bus.chx_data_valid_h, bus.chx_data_take_h};
    n_vec++; if (ctl !== 7'b0 || bus.mb_adr_h !== '0 || bus.chx_data_h !== '0) begin
      n_err++; $display("FAIL mid_rst: got ctl %b adr %o data %h want 0 0 0", ctl,
                        bus.mb_adr_h, bus.chx_data_h); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (bus.chx_cbus_ack_h !== 1'b0) acks++;
    end
    n_vec++; if (acks !== 0 || bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL mid_noack: got %0d acks busy %b want 0 0", acks, bus.chx_busy_h);
    end
    @(negedge clk);
    bus.ch_cbus_req_h = 1'b1; bus.ch_store_h = 1'b1; bus.ch_num_h = 3'd7;
    bus.ch_adr_h = 22'o200;
    @(negedge clk); bus.mb_ack_h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mb_ack_h = 1'b0; bus.mb_word_en_h = 1'b1; bus.ch_data_h = DATA_W'(100 + i);
      #1;
      n_vec++; if (bus.mb_adr_h !== ADR_W'(22'o200 + i) || bus.chx_data_take_h !== 1'b1 ||
                   bus.mb_wdata_h !== DATA_W'(100 + i)) begin
        n_err++; $display("FAIL mid_new w%0d: got adr %o take %b wdata %0d", i, bus.mb_adr_h,
                          bus.chx_data_take_h, bus.mb_wdata_h); end
    end
    @(negedge clk); bus.mb_word_en_h = 1'b0; bus.ch_cbus_req_h = 1'b0; #1;
    n_vec++; if (bus.chx_cbus_ack_h !== 1'b1 || bus.chx_err_h !== 1'b0 ||
                 bus.chx_ack_num_h !== 3'd7) begin
      n_err++; $display("FAIL mid_ack: got ack %b err %b num %0d want 1 0 7", bus.chx_cbus_ack_h,
                        bus.chx_err_h, bus.chx_ack_num_h); end
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus.chx_busy_h !== 1'b0) begin
      n_err++; $display("FAIL mid_busy: got %b want 0", bus.chx_busy_h); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_read_quad();
    test_store_wrap();
    test_nxm();
    test_word_gap();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chx_cbus_resp.md
Name: chx_cbus_resp

Overview:
- Memory-side responder for channel CBUS requests: accepts one channel memory request at a time and runs the MB cycle against the memory buffer.
- Streams a quad-word burst in either direction: store from the channel, or read back to the channel.
- Returns completion or error to the requesting channel control.
- Sits between the channel control request logic and the MB memory port.

Parameters:
- ADR_W, 22, physical word address width
- DATA_W, 36, word width
- WORDS_PER_REQ, 4, words per CBUS request (power of 2, 1..4)
- TIMEOUT, 15, max cycles waiting for mb_ack_h or between mb_word_en_h pulses before NXM error

Ports:
- clk_chx_h  in  1  clock, all state on rising edge
- chx_reset_l  in  1  asynchronous active-low reset
- ch_cbus_req_h  in  1  channel memory request, held until chx_cbus_ack_h
- ch_store_h  in  1  1 = store to memory, 0 = read; sampled with request
- ch_num_h  in  3  requesting channel number
- ch_adr_h  in  ADR_W  starting word address
- ch_data_h  in  DATA_W  store word, valid while request is held
- chx_data_take_h  out  1  store word consumed this cycle; channel advances ch_data_h
- chx_data_valid_h  out  1  read word on chx_data_h valid this cycle
- chx_data_h  out  DATA_W  read data to channel
- chx_cbus_ack_h  out  1  one-cycle completion strobe
- chx_ack_num_h  out  3  channel number qualifying ack/err
- chx_err_h  out  1  NXM/timeout, coincident with ack
- chx_busy_h  out  1  not IDLE
- mb_req_h  out  1  MB cycle request, held until mb_ack_h
- mb_wr_h  out  1  MB write cycle
- mb_adr_h  out  ADR_W  current word address
- mb_wdata_h  out  DATA_W  store data to MB
- mb_ack_h  in  1  MB grant
- mb_word_en_h  in  1  one word transferred this cycle
- mb_rdata_h  in  DATA_W  read data from MB

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; counters 0; mb_req_h drops immediately. No ack is issued for an aborted operation.
- States: IDLE, REQ, XFER, DONE, ERR, HOLD.
- IDLE:
  - On ch_cbus_req_h: latch ch_num_h, ch_adr_h, ch_store_h; clear timeout; go to REQ next cycle.
- REQ:
  - mb_req_h=1; mb_wr_h=latched store; mb_adr_h=latched address.
  - Timeout counts each cycle.
  - mb_ack_h -> XFER with word count 0 and timeout cleared.
  - Timeout reaching TIMEOUT with no ack -> ERR.
  - mb_ack_h in the same cycle as expiry: ack wins.
- XFER:
  - mb_req_h=0.
  - mb_adr_h = {latched[ADR_W-1:2], latched[1:0] + wcnt}; low two bits wrap within the quad.
  - Store: mb_wdata_h = ch_data_h (combinational); chx_data_take_h = mb_word_en_h.
  - Read: on mb_word_en_h, register chx_data_h <= mb_rdata_h; chx_data_valid_h=1 next cycle only (1-cycle latency).
  - Each mb_word_en_h increments wcnt and clears timeout; otherwise timeout counts.
  - After WORDS_PER_REQ words -> DONE.
  - Timeout expiry -> ERR (partial transfer; already-moved words are not rolled back).
- DONE:
  - chx_cbus_ack_h=1 and chx_ack_num_h=latched number for one cycle -> HOLD.
  - For reads, the final chx_data_valid_h coincides with ack.
- ERR:
  - chx_cbus_ack_h=1, chx_err_h=1, chx_ack_num_h valid for one cycle -> HOLD.
- HOLD:
  - One cycle; ch_cbus_req_h is ignored so a request the channel is still dropping is not restarted. Then -> IDLE.
  - A request still high in IDLE after HOLD is a new request.
- Back-to-back turnaround: ack cycle, HOLD, IDLE, REQ. Minimum of 3 cycles from ack to next mb_req_h.
- Requester drops ch_cbus_req_h mid-operation: ignored; the operation completes and acks.
- mb_word_en_h outside XFER: ignored.
- chx_busy_h = state != IDLE.

Decomposition:
- Package chx_pkg:
  - state enum (IDLE, REQ, XFER, DONE, ERR, HOLD)
  - default ADR_W/DATA_W constants
  - channel number typedef (3 bits)
- Sub-module chx_timeout:
  - clear/count/expire counter
  - width $clog2(TIMEOUT+1)
  - reused for the ack wait and the inter-word gap
- Word counter: inline, width $clog2(WORDS_PER_REQ)+1.

Test Plan:
- Read quad: ch_num=5, adr=0o1234, store=0; mb_ack after 2 cycles; 4 consecutive word_en with data 1..4 -> mb_adr 0o1234, 0o1235, 0o1236, 0o1237; chx_data_valid 1 cycle after each word with data 1..4; ack with num=5 on the last valid; err=0.
- Store with wrap: adr=0o1236, store=1, data stepping A..D on take -> mb_adr 0o1236, 0o1237, 0o1234, 0o1235; mb_wdata A..D; 4 take pulses; ack.
- NXM: mb_ack never asserted -> mb_req held 15 cycles then dropped; ack+err one cycle with chx_ack_num_h = request number; busy 0 two cycles later.
- Word-gap timeout: ack, 2 words, then silence -> err after 15 idle cycles; exactly 2 take/valid pulses.
- Request held through HOLD: req stays high after ack -> exactly one new mb_req, starting 3 cycles after ack; no duplicate.
- Reset mid-XFER: drop chx_reset_l after word 2 -> all outputs 0 asynchronously; no ack; new request after release runs normally.
